// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave. Async SPI pins are synchronised into clk, MOSI is deserialised MSB first
// and tx_data is serialised onto MISO, reloading at the first sclk fall after each word.
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          bit_cnt_reg, bit_cnt_next;
  // Shift registers hold only W-1 bits: the final rx bit comes straight from mosi_s,
  // and the current tx bit lives in miso_reg.
  logic [DATA_WIDTH-2:0]  rx_shift_reg, rx_shift_next;
  logic [DATA_WIDTH-2:0]  tx_shift_reg, tx_shift_next;
  logic                   word_done_reg, word_done_next;
  logic                   miso_reg, miso_next;
  logic                   oe_reg, oe_next;
  logic [DATA_WIDTH-1:0]  rx_data_reg, rx_data_next;
  logic                   rx_valid_reg, rx_valid_next;
  logic                   tx_load_reg, tx_load_next;
  logic                   frame_err_reg, frame_err_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      rx_shift_reg  <= '0;
      tx_shift_reg  <= '0;
      word_done_reg <= 1'b0;
      miso_reg      <= 1'b0;
      oe_reg        <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      tx_load_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_shift_reg  <= rx_shift_next;
      tx_shift_reg  <= tx_shift_next;
      word_done_reg <= word_done_next;
      miso_reg      <= miso_next;
      oe_reg        <= oe_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      tx_load_reg   <= tx_load_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    rx_shift_next  = rx_shift_reg;
    tx_shift_next  = tx_shift_reg;
    word_done_next = word_done_reg;
    miso_next      = miso_reg;
    oe_next        = oe_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
    tx_load_next   = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next     = ACTIVE;
          bit_cnt_next   = '0;
          tx_shift_next  = tx_data[DATA_WIDTH-2:0];
          miso_next      = tx_data[DATA_WIDTH-1];
          tx_load_next   = 1'b1;
          oe_next        = 1'b1;
          word_done_next = 1'b0;
        end
      end
      ACTIVE: begin
        // A chip-select edge outranks any sclk edge seen in the same cycle.
        if (cs_rise) begin
          state_next     = IDLE;
          miso_next      = 1'b0;
          oe_next        = 1'b0;
          bit_cnt_next   = '0;
          rx_shift_next  = '0;
          word_done_next = 1'b0;
          frame_err_next = (bit_cnt_reg != '0);
        end else if (sclk_rise) begin
          rx_shift_next = {rx_shift_reg[DATA_WIDTH-3:0], mosi_s};
          if (bit_cnt_reg == LAST_BIT) begin
            rx_data_next   = {rx_shift_reg, mosi_s};
            rx_valid_next  = 1'b1;
            bit_cnt_next   = '0;
            word_done_next = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else if (sclk_fall) begin
          if (word_done_reg) begin
            tx_shift_next  = tx_data[DATA_WIDTH-2:0];
            miso_next      = tx_data[DATA_WIDTH-1];
            tx_load_next   = 1'b1;
            word_done_next = 1'b0;
          end else begin
            miso_next     = tx_shift_reg[DATA_WIDTH-2];
            tx_shift_next = {tx_shift_reg[DATA_WIDTH-3:0], 1'b0};
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign miso      = miso_reg;
  assign miso_oe   = oe_reg;
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign tx_load   = tx_load_reg;
  assign frame_err = frame_err_reg;

endmodule
